// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared defaults, FSM state type and row-index sizing for the systolic-array drain
package sa_pkg;

    localparam int N_DEF         = 4;
    localparam int ACC_WIDTH_DEF = 64;
    localparam int OUT_WIDTH_DEF = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_W = row_w(N_DEF);

endpackage

// File: rtl/sa_drain_if.sv
// rtl/sa_drain_if.sv - row-beat result stream between the drain and its consumer
interface sa_drain_if #(
    parameter int N         = 4,
    parameter int OUT_WIDTH = 32
) ();

    logic                   m_valid_o;
    logic                   m_ready_i;
    logic [N*OUT_WIDTH-1:0] m_data_o;
    logic [N-1:0]           m_sat_o;
    logic                   m_last_o;

    modport master (
        output m_valid_o,
        output m_data_o,
        output m_sat_o,
        output m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_valid_o,
        input  m_data_o,
        input  m_sat_o,
        input  m_last_o,
        output m_ready_i
    );

endinterface

// File: rtl/sa_requant.sv
// rtl/sa_requant.sv - arithmetic right shift then signed saturation of one accumulator
module sa_requant #(
    parameter int ACC_WIDTH = 64,
    parameter int OUT_WIDTH = 32,
    parameter int SHIFT     = 0
) (
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [OUT_WIDTH-1:0] q,
    output logic                 sat
);

    localparam logic signed [ACC_WIDTH-1:0] MAX_V =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_V =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] shifted;

    always_comb begin
        shifted = $signed(acc) >>> SHIFT;
        q       = shifted[OUT_WIDTH-1:0];
        sat     = 1'b0;
        if (shifted > MAX_V) begin
            q   = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            sat = 1'b1;
        end else if (shifted < MIN_V) begin
            q   = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/sa_drain.sv
// rtl/sa_drain.sv - snapshots the PE grid, requantizes every element and streams one row per beat
module sa_drain
    import sa_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int SHIFT     = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start_i,
    input  logic [N*N*ACC_WIDTH-1:0] acc_i,
    output logic                     busy_o,
    output logic                     cap_done_o,
    sa_drain_if.master               m
);

    localparam int RW = row_w(N);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    state_t                 state;
    logic [RW-1:0]          row_idx;
    logic [RW-1:0]          nxt_row;
    logic [OUT_WIDTH-1:0]   q_buf   [N*N];
    logic [N*N-1:0]         sat_buf;
    logic [OUT_WIDTH-1:0]   req_q   [N*N];
    logic [N*N-1:0]         req_sat;
    logic [N*OUT_WIDTH-1:0] row0_data;
    logic [N-1:0]           row0_sat;
    logic [N*OUT_WIDTH-1:0] nxt_data;
    logic [N-1:0]           nxt_sat;

    for (genvar i = 0; i < N*N; i++) begin : g_rq
        sa_requant #(
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .SHIFT     (SHIFT)
        ) u_rq (
            .acc (acc_i[i*ACC_WIDTH +: ACC_WIDTH]),
            .q   (req_q[i]),
            .sat (req_sat[i])
        );
    end

    // Outputs are registered: row 0 comes straight from the requantizers at capture,
    // later rows from the buffer, so m_ready_i never reaches the outputs combinationally.
    always_comb begin
        nxt_row   = row_idx + 1'b1;
        row0_data = '0;
        row0_sat  = '0;
        nxt_data  = '0;
        nxt_sat   = '0;
        for (int c = 0; c < N; c++) begin
            row0_data[c*OUT_WIDTH +: OUT_WIDTH] = req_q[c];
            row0_sat[c]                         = req_sat[c];
            nxt_data[c*OUT_WIDTH +: OUT_WIDTH]  = q_buf[int'(nxt_row)*N + c];
            nxt_sat[c]                          = sat_buf[int'(nxt_row)*N + c];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            row_idx     <= '0;
            busy_o      <= 1'b0;
            cap_done_o  <= 1'b0;
            m.m_valid_o <= 1'b0;
            m.m_last_o  <= 1'b0;
            m.m_data_o  <= '0;
            m.m_sat_o   <= '0;
            sat_buf     <= '0;
            for (int i = 0; i < N*N; i++) begin
                q_buf[i] <= '0;
            end
        end else begin
            cap_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        for (int i = 0; i < N*N; i++) begin
                            q_buf[i] <= req_q[i];
                        end
                        sat_buf     <= req_sat;
                        row_idx     <= '0;
                        state       <= STREAM;
                        busy_o      <= 1'b1;
                        cap_done_o  <= 1'b1;
                        m.m_valid_o <= 1'b1;
                        m.m_data_o  <= row0_data;
                        m.m_sat_o   <= row0_sat;
                        m.m_last_o  <= (N == 1);
                    end
                end
                STREAM: begin
                    if (m.m_ready_i) begin
                        if (row_idx == LAST_ROW) begin
                            state       <= IDLE;
                            row_idx     <= '0;
                            busy_o      <= 1'b0;
                            m.m_valid_o <= 1'b0;
                            m.m_last_o  <= 1'b0;
                            m.m_data_o  <= '0;
                            m.m_sat_o   <= '0;
                        end else begin
                            row_idx    <= nxt_row;
                            m.m_data_o <= nxt_data;
                            m.m_sat_o  <= nxt_sat;
                            m.m_last_o <= (nxt_row == LAST_ROW);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_drain.sv
// tb/tb_sa_drain.sv - directed bench for sa_drain with a frame-level reference model
module tb_sa_drain;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int OW = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b0;
    longint acc [N*N];
    logic [N*N*AW-1:0] acc_flat;
    logic busy0, busy1, cap0, cap1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int hs_cnt = 0;
    int cap_cnt = 0;

    always_comb begin
        acc_flat = '0;
        for (int i = 0; i < N*N; i++) acc_flat[i*AW +: AW] = acc[i];
    end

    sa_drain_if #(.N(N), .OUT_WIDTH(OW)) if0 ();
    sa_drain_if #(.N(N), .OUT_WIDTH(OW)) if1 ();
    assign if0.m_ready_i = ready;
    assign if1.m_ready_i = ready;

    sa_drain #(.N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(0)) dut0 (
        .clk(clk), .rstn(rstn), .start_i(start), .acc_i(acc_flat),
        .busy_o(busy0), .cap_done_o(cap0), .m(if0.master));
    sa_drain #(.N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(8)) dut1 (
        .clk(clk), .rstn(rstn), .start_i(start), .acc_i(acc_flat),
        .busy_o(busy1), .cap_done_o(cap1), .m(if1.master));

    always #5 clk = ~clk;

    // Frame-level model: a snapshot plus the row the consumer is waiting for.
    bit     m_active = 0;
    bit     m_cap = 0;
    int     m_row = 0;
    longint snap [N*N];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active = 0;
            m_cap    = 0;
            m_row    = 0;
        end else begin
            m_cap = 0;
            if (m_active) begin
                if (ready) begin
                    if (m_row == N-1) m_active = 0;
                    else m_row++;
                end
            end else if (start) begin
                snap     = acc;
                m_active = 1;
                m_row    = 0;
                m_cap    = 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rstn && if0.m_valid_o && ready) hs_cnt++;
        if (rstn && cap0) cap_cnt++;
    end

    function automatic logic [32:0] req(input longint v, input int sh);
        longint s;
        s = v >>> sh;
        if (s > 64'sd2147483647)  return {1'b1, 32'h7fff_ffff};
        if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        return {1'b0, s[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic check_dut(input string tag, input int sh, input logic busy, input logic cap,
                             input logic valid, input logic last,
                             input logic [N*OW-1:0] data, input logic [N-1:0] sat);
        logic [N*OW-1:0] ed;
        logic [N-1:0]    es;
        logic [32:0]     r;
        if (!rstn) begin
            chk({tag, ".rst_valid"}, valid, 0);
            chk({tag, ".rst_busy"}, busy, 0);
            chk({tag, ".rst_cap"}, cap, 0);
            chk({tag, ".rst_last"}, last, 0);
            chk({tag, ".rst_data"}, data, 0);
            chk({tag, ".rst_sat"}, sat, 0);
        end else begin
            chk({tag, ".busy"}, busy, m_active);
            chk({tag, ".valid"}, valid, m_active);
            chk({tag, ".cap_done"}, cap, m_cap);
            if (m_active) begin
                for (int c = 0; c < N; c++) begin
                    r = req(snap[m_row*N + c], sh);
                    ed[c*OW +: OW] = r[31:0];
                    es[c] = r[32];
                end
                chk({tag, ".data"}, data, ed);
                chk({tag, ".sat"}, sat, es);
                chk({tag, ".last"}, last, (m_row == N-1));
            end
        end
    endtask

    always @(negedge clk) begin
        check_dut("d0", 0, busy0, cap0, if0.m_valid_o, if0.m_last_o, if0.m_data_o, if0.m_sat_o);
        check_dut("d1", 8, busy1, cap1, if1.m_valid_o, if1.m_last_o, if1.m_data_o, if1.m_sat_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 40; i++) begin
            if (!done) begin
                @(negedge clk);
                if (!busy0 && !busy1) done = 1;
            end
        end
        chk("idle_timeout", done, 1);
        tick();
    endtask

    initial begin
        int h0, c0;
        bit bp [7];
        bp = '{1, 0, 0, 1, 0, 1, 1};
        for (int i = 0; i < N*N; i++) acc[i] = 0;
        tick();
        tick();
        chk("reset_valid", if0.m_valid_o, 0);
        rstn = 1'b1;
        tick();

        // basic drain
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) acc[r*N + c] = 10*r + c;
        ready = 1'b1;
        c0 = cap_cnt;
        pulse_start();
        for (int b = 0; b < N; b++) begin
            @(negedge clk);
            chk("basic_valid", if0.m_valid_o, 1);
            chk("basic_last", if0.m_last_o, (b == 3));
            if (b == 2) chk("basic_row2", if0.m_data_o, 128'h00000017_00000016_00000015_00000014);
        end
        @(negedge clk);
        chk("basic_done_valid", if0.m_valid_o, 0);
        chk("basic_cap_pulses", cap_cnt - c0, 1);
        tick();

        // saturation and shift
        for (int i = 0; i < N*N; i++) acc[i] = 0;
        acc[0] = 64'h0000_0100_0000_0000;
        acc[1] = -(64'sd1 <<< 50);
        acc[2] = 64'h0012_3400;
        acc[3] = -256;
        pulse_start();
        @(negedge clk);
        chk("sat_shift8_data", if1.m_data_o, 128'hFFFFFFFF_00001234_80000000_7FFFFFFF);
        chk("sat_shift8_flags", if1.m_sat_o, 4'b0011);
        chk("sat_shift0_data", if0.m_data_o, 128'hFFFFFF00_00123400_80000000_7FFFFFFF);
        wait_idle();

        // backpressure
        for (int i = 0; i < N*N; i++) acc[i] = 100 + i;
        h0 = hs_cnt;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            ready = bp[i];
            tick();
        end
        ready = 1'b1;
        wait_idle();
        chk("bp_handshakes", hs_cnt - h0, 4);

        // start during stream, then start right after IDLE is re-entered
        for (int i = 0; i < N*N; i++) acc[i] = 1000 + i;
        pulse_start();
        tick();
        for (int i = 0; i < N*N; i++) acc[i] = 2000 + i;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        @(negedge clk);
        chk("restart_idle", busy0, 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("restart_cap", cap0, 1);
        chk("restart_row0", if0.m_data_o, 128'h000007D3_000007D2_000007D1_000007D0);
        wait_idle();

        // input change after capture
        for (int i = 0; i < N*N; i++) acc[i] = 3*i + 7;
        pulse_start();
        for (int i = 0; i < N*N; i++) acc[i] = -1;
        @(negedge clk);
        chk("held_row0", if0.m_data_o, 128'h00000010_0000000D_0000000A_00000007);
        wait_idle();

        // asynchronous reset during a stall on beat 1
        for (int i = 0; i < N*N; i++) acc[i] = 50 + i;
        pulse_start();
        tick();
        ready = 1'b0;
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("arst_valid", if0.m_valid_o, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_data", if0.m_data_o, 0);
        chk("arst_last", if0.m_last_o, 0);
        tick();
        tick();
        rstn = 1'b1;
        ready = 1'b1;
        repeat (5) tick();
        chk("arst_no_beats", busy0, 0);
        h0 = hs_cnt;
        pulse_start();
        wait_idle();
        chk("arst_new_frame", hs_cnt - h0, 4);

        repeat (2) tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sa_drain.md
# sa_drain

Output drain for the systolic array. On a `start_i` pulse it snapshots all N×N PE accumulator outputs in one cycle. It requantizes each value to OUT_WIDTH by an arithmetic shift followed by saturation, then streams the result out one array row per beat over a valid/ready interface. It sits between the PE grid's `acc_o` outputs and the downstream result consumer (writeback or next FFN layer).

## Interface
- N, 4, array dimension (N×N PEs)
- ACC_WIDTH, 64, PE accumulator width
- OUT_WIDTH, 32, output element width; must be ≤ ACC_WIDTH
- SHIFT, 0, arithmetic right shift applied before saturation; range 0..ACC_WIDTH-1
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle pulse; capture acc_i (array results final this cycle)
- acc_i  in  N*N*ACC_WIDTH  flattened signed accumulators; PE(r,c) at slice index r*N+c
- busy_o  out  1  high from capture until last row accepted
- cap_done_o  out  1  one-cycle pulse the cycle after capture; array controller may clear/restart PEs
- m_valid_o  out  1  row beat valid
- m_ready_i  in  1  consumer ready
- m_data_o  out  N*OUT_WIDTH  current row, column c at slice c (signed)
- m_sat_o  out  N  per-column flag: that element saturated
- m_last_o  out  1  current beat is row N-1

## Operation
- FSM states IDLE, STREAM.
- IDLE: on start_i=1:
  - register q(r,c) = sat(acc(r,c) >>> SHIFT) and its saturation flag for every r,c
  - row_idx <= 0, go STREAM.
- STREAM:
  - m_valid_o=1; m_data_o/m_sat_o driven from the stored row row_idx; m_last_o = (row_idx==N-1).
  - Handshake = m_valid_o & m_ready_i. On handshake with row_idx<N-1: row_idx+1.
  - On handshake with row_idx==N-1: go IDLE.
- Stall: while m_valid_o=1 and m_ready_i=0, m_data_o, m_sat_o, m_last_o, row_idx hold stable. m_valid_o never drops before the handshake.
- sat(): signed compare of shifted value against [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]:
  - above range → max, flag 1
  - below range → min, flag 1
  - otherwise → low OUT_WIDTH bits, flag 0
- start_i while in STREAM (including the final-handshake cycle) is ignored. The buffer is not overwritten.
- busy_o = (state==STREAM).

## Timing
- Reset values: state IDLE, row_idx 0, busy_o 0, cap_done_o 0, m_valid_o 0, m_last_o 0, m_data_o 0, m_sat_o 0, buffer 0.
- Capture latency: start_i high in cycle t → cap_done_o, busy_o, m_valid_o high in cycle t+1, with row 0 on m_data_o.
- With m_ready_i held high, N beats occupy cycles t+1..t+N. State is IDLE in t+N+1, and the earliest accepted next start_i is in t+N+1.
- acc_i is sampled only in the capture cycle. The array may change acc_i freely from t+1.
- Reset asserted mid-stream: outputs go to reset values immediately (asynchronous). The in-flight frame is discarded and no partial beats follow deassertion.
- No combinational path from m_ready_i to m_valid_o or m_data_o.

## Structure
- Shared package sa_pkg holds:
  - default N, ACC_WIDTH, OUT_WIDTH
  - state enum typedef (IDLE, STREAM)
  - row-index width constant $clog2(N) (min 1)
- Sub-module sa_requant: one per element, combinational.
  - Parameters ACC_WIDTH, OUT_WIDTH, SHIFT.
  - Inputs: acc. Outputs: q, sat.
  - Instantiated N*N times in a generate loop feeding the capture registers.
- Top holds FSM, row counter, N×N×(OUT_WIDTH+1) buffer, and row mux.

## Test plan
- Basic drain: N=4, SHIFT=0, acc(r,c)=10*r+c, ready held 1, start pulse:
  - 4 beats on consecutive cycles
  - beat 2 data = {20,21,22,23}, m_last_o only on beat 3
  - m_sat_o=0, cap_done_o single pulse.
- Saturation/shift: SHIFT=8, acc(0,0)=0x0000_0100_0000_0000 → 0x7FFF_FFFF sat=1; acc(0,1)=-2^50 → 0x8000_0000 sat=1; acc(0,2)=0x1234_00 → 0x1234 sat=0; acc(0,3)=-256 → -1 sat=0.
- Backpressure: ready toggles 1,0,0,1,0,1,1:
  - data/last stable during stalls
  - exactly 4 handshakes, rows in order 0..3, no duplicates or skips.
- Start during stream: second start_i with different acc_i on beat 1 and on the final-handshake cycle:
  - ignored; all beats carry the first snapshot
  - start in the cycle after IDLE is re-entered is captured.
- Input change after capture: acc_i changed to all 0xFF..F in cycle t+1 → streamed data still equals the cycle-t values.
- Reset mid-stream: rstn low during beat 1 stall:
  - all outputs reset immediately
  - after release, no beats until a new start_i, which then drains a full 4-beat frame.
